ysyx_24110006_idu_fifo: RTL and testbench
=========================================

YSYX_24110006_IDU_FIFO -- requirements
Module: ysyx_24110006_idu_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of buffered instruction entries; power of two, at least 2.
REQ-002 SHALL have parameter IMM_EXT, default 0, meaning immediate source: 0 = generated internally from the instruction, 1 = taken from i_imm.
REQ-003 SHALL have port i_clock, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset_n, input, 1 bit, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port i_inst, input, 32 bits, meaning the instruction word from the fetch stage.
REQ-006 SHALL have port i_imm, input, 32 bits, meaning the external immediate; stored per entry only when IMM_EXT=1.
REQ-007 SHALL have port i_valid, input, 1 bit, meaning upstream offers i_inst/i_imm this cycle.
REQ-008 SHALL have port o_ready, output, 1 bit, meaning the block accepts an entry this cycle.
REQ-009 SHALL have port i_flush, input, 1 bit, meaning discard all buffered entries.
REQ-010 SHALL have port o_valid, output, 1 bit, meaning the head entry is presented on the decode outputs.
REQ-011 SHALL have port i_ready, input, 1 bit, meaning downstream consumes the head entry this cycle.
REQ-012 SHALL have ports o_op (7 bits), o_func (3), o_reg_rd (5), o_reg_rs1 (5), o_reg_rs2 (5), o_imm (32) and o_csr_t (3), all outputs, meaning the decoded fields of the head entry.
REQ-013 SHALL have port o_count, output, $clog2(DEPTH)+1 bits, meaning the current occupancy.

Function
REQ-014 SHALL be a circular FIFO with read pointer, write pointer and count; both pointers wrap modulo DEPTH.
REQ-015 SHALL drive o_ready = (count != DEPTH) and o_valid = (count != 0).
REQ-016 SHALL enqueue on i_valid && o_ready, but only when i_flush is low.
REQ-017 SHALL dequeue on o_valid && i_ready, but only when i_flush is low.
REQ-018 SHALL, when full, hold o_ready low even if a dequeue occurs in the same cycle; no same-cycle refill of a full FIFO.
REQ-019 SHALL, on a simultaneous enqueue and dequeue with count between 1 and DEPTH-1, leave count unchanged and advance both pointers.
REQ-020 SHALL, when i_flush=1, on that edge set count, read pointer and write pointer to 0, overriding enqueue and dequeue; stored data need not be cleared.
REQ-021 SHALL give a latency of exactly one cycle: an entry accepted at edge N appears at the head (if the FIFO was empty) with o_valid=1 after edge N.
REQ-022 SHALL decode all outputs combinationally from the head entry: o_op=[6:0], o_func=[14:12], o_reg_rd=[11:7], o_reg_rs1=[19:15], o_reg_rs2=[24:20].
REQ-023 SHALL, when the FIFO is empty, drive o_op, o_func, the register fields and o_imm to 0, and o_csr_t to 3'b111.
REQ-024 SHALL, when IMM_EXT=0, generate o_imm by opcode:
  - I-type for opcodes 0010011, 0000011, 1100111 and 1110011
  - U-type for opcodes 0110111 and 0010111
  - J-type for opcode 1101111
  - S-type for opcode 0100011
  - B-type for opcode 1100011
  - all fields use standard RV32 sign extension from bit 31
  - every other opcode gives 0
REQ-025 SHALL, when IMM_EXT=1, drive o_imm with the i_imm value stored alongside the head entry.
REQ-026 SHALL decode o_csr_t only for opcode 1110011; any other opcode gives NONE 3'b111. The SYSTEM encodings are:
  - func 000 with inst[21]=1: MRET 3'b000
  - func 000 with inst[20]=1 and inst[21]=0: EBREAK 3'b010
  - func 000 otherwise: ECALL 3'b011
  - func x01: CSRW 3'b001
  - func x10: CSRS 3'b100
  - func x11: CSRC 3'b101
  - func 100: NONE 3'b111
REQ-027 SHALL decode o_csr_t from the stored instruction bits, independent of IMM_EXT.

Reset
REQ-028 SHALL, while i_reset_n=0, immediately force count, read pointer and write pointer to 0, so that o_valid=0, o_ready=1, o_count=0 and o_csr_t=3'b111.
REQ-029 SHALL, on reset asserted mid-operation, discard all entries; the first edge after i_reset_n rises may accept a new entry.
REQ-030 SHALL not require entry storage to be reset.

Verification
REQ-031 SHALL check this scenario: DEPTH=2, IMM_EXT=0, enqueue 0x00500093 (addi x1,x0,5) -> next cycle o_valid=1, o_op=0010011, o_reg_rd=1, o_imm=5, o_csr_t=3'b111.
REQ-032 SHALL check this scenario: i_ready=0, enqueue 3 instructions back-to-back -> the first 2 are accepted, o_ready=0 with o_count=2, and the third is held upstream; then i_ready=1 for 1 cycle -> o_count=1 and o_ready=1.
REQ-033 SHALL check this scenario: enqueue 0x30200073, 0x00000073, 0x00100073 and 0x30529073 in turn -> o_csr_t=000, then 011, then 010, then 001.
REQ-034 SHALL check this scenario: enqueue 0xFE000EE3 (beq x0,x0,-4) -> o_imm=0xFFFFFFFC; enqueue 0x800000EF (jal) -> o_imm=0xFFF00000.
REQ-035 SHALL check this scenario: with count=1, assert i_flush together with i_valid and i_ready -> after the edge o_count=0, o_valid=0, and nothing is enqueued.
REQ-036 SHALL check this scenario: IMM_EXT=1, DEPTH=4, fill 4 entries with i_imm=1..4 while pointers wrap -> o_imm dequeues as 1, 2, 3, 4 in order; pulse i_reset_n low mid-stream -> o_valid=0 immediately.

Source files
------------

// File: rtl/ysyx_24110006_idu_fifo.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_idu_fifo
//   Instruction buffer between fetch and decode. A circular FIFO of DEPTH
//   entries stores raw instruction words (and, optionally, an externally
//   supplied immediate). The head entry is decoded combinationally into
//   opcode, funct3, register indices, immediate and a CSR/system class.
//
// Parameters
//   DEPTH   : number of buffered entries (power of two, >= 2)
//   IMM_EXT : 0 = immediate generated from the instruction bits,
//             1 = immediate taken from i_imm stored with the entry
//
// Ports
//   i_clock, i_reset_n        : clock, asynchronous active-low reset
//   i_inst, i_imm, i_valid    : upstream entry offer
//   o_ready                   : entry accepted this cycle when i_valid
//   i_flush                   : drop every buffered entry on this edge
//   o_valid, i_ready          : head entry presented / consumed
//   o_op .. o_csr_t           : decoded fields of the head entry
//   o_count                   : current occupancy
// ---------------------------------------------------------------------------
module ysyx_24110006_idu_fifo #(
  parameter int DEPTH   = 2,
  parameter int IMM_EXT = 0
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic [31:0]              i_inst,
  input  logic [31:0]              i_imm,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_flush,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [6:0]               o_op,
  output logic [2:0]               o_func,
  output logic [4:0]               o_reg_rd,
  output logic [4:0]               o_reg_rs1,
  output logic [4:0]               o_reg_rs2,
  output logic [31:0]              o_imm,
  output logic [2:0]               o_csr_t,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] CSR_MRET   = 3'b000;
  localparam logic [2:0] CSR_CSRW   = 3'b001;
  localparam logic [2:0] CSR_EBREAK = 3'b010;
  localparam logic [2:0] CSR_ECALL  = 3'b011;
  localparam logic [2:0] CSR_CSRS   = 3'b100;
  localparam logic [2:0] CSR_CSRC   = 3'b101;
  localparam logic [2:0] CSR_NONE   = 3'b111;

  // RV32 immediate generation; all formats sign-extend from inst[31].
  function automatic logic [31:0] gen_imm(input logic [31:0] inst);
    logic [31:0] imm;
    case (inst[6:0])
      OP_OPIMM, OP_LOAD, OP_JALR, OP_SYSTEM:
        imm = {{20{inst[31]}}, inst[31:20]};
      OP_LUI, OP_AUIPC:
        imm = {inst[31:12], 12'h000};
      OP_JAL:
        imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      OP_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      default:
        imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

  // SYSTEM-opcode classification; funct3[2] only matters for the 100 case.
  function automatic logic [2:0] dec_csr(input logic [31:0] inst);
    logic [2:0] csr;
    if (inst[6:0] == OP_SYSTEM) begin
      case (inst[14:12])
        3'b000: begin
          if (inst[21]) begin
            csr = CSR_MRET;
          end else if (inst[20]) begin
            csr = CSR_EBREAK;
          end else begin
            csr = CSR_ECALL;
          end
        end
        3'b001, 3'b101: csr = CSR_CSRW;
        3'b010, 3'b110: csr = CSR_CSRS;
        3'b011, 3'b111: csr = CSR_CSRC;
        default:        csr = CSR_NONE;
      endcase
    end else begin
      csr = CSR_NONE;
    end
    return csr;
  endfunction

  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   imm_mem_q  [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          enq_s, deq_s, empty_s, full_s;
  logic [31:0]   head_inst_s, head_imm_s;

  assign empty_s = (count_q == {CW{1'b0}});
  // A full FIFO stays not-ready even when the head is consumed this cycle.
  assign full_s  = (count_q == FULL_COUNT);
  assign enq_s   = i_valid & ~full_s & ~i_flush;
  assign deq_s   = ~empty_s & i_ready & ~i_flush;

  assign o_ready = ~full_s;
  assign o_valid = ~empty_s;
  assign o_count = count_q;

  assign head_inst_s = inst_mem_q[rd_ptr_q];
  assign head_imm_s  = imm_mem_q[rd_ptr_q];

  // Next pointer/occupancy; flush overrides any handshake on the same edge.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (enq_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; written on enqueue only and never cleared.
  always_ff @(posedge i_clock) begin
    if (enq_s) begin
      inst_mem_q[wr_ptr_q] <= i_inst;
      imm_mem_q[wr_ptr_q]  <= i_imm;
    end
  end

  // Head-entry decode, forced to idle values while the FIFO is empty.
  always_comb begin
    o_op      = 7'b000_0000;
    o_func    = 3'b000;
    o_reg_rd  = 5'b0_0000;
    o_reg_rs1 = 5'b0_0000;
    o_reg_rs2 = 5'b0_0000;
    o_imm     = 32'h0000_0000;
    o_csr_t   = CSR_NONE;
    if (!empty_s) begin
      o_op      = head_inst_s[6:0];
      o_func    = head_inst_s[14:12];
      o_reg_rd  = head_inst_s[11:7];
      o_reg_rs1 = head_inst_s[19:15];
      o_reg_rs2 = head_inst_s[24:20];
      o_imm     = (IMM_EXT != 32'sd0) ? head_imm_s : gen_imm(head_inst_s);
      o_csr_t   = dec_csr(head_inst_s);
    end else begin
      o_op      = 7'b000_0000;
      o_func    = 3'b000;
      o_reg_rd  = 5'b0_0000;
      o_reg_rs1 = 5'b0_0000;
      o_reg_rs2 = 5'b0_0000;
      o_imm     = 32'h0000_0000;
      o_csr_t   = CSR_NONE;
    end
  end

endmodule

// File: tb/tb_ysyx_24110006_idu_fifo.sv
// ---------------------------------------------------------------------------
// Bench for ysyx_24110006_idu_fifo. Two instances share one input stream:
//   dut_a : DEPTH=2, IMM_EXT=0 (internal immediate generation)
//   dut_b : DEPTH=4, IMM_EXT=1 (immediate taken from i_imm)
// A reference queue per instance is filled at each clock edge from the
// handshake rules; a monitor on the falling edge compares occupancy and the
// presented head entry against the front of that queue.
// ---------------------------------------------------------------------------
module tb_ysyx_24110006_idu_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst, imm_in;
  logic        valid, ready, flush;

  logic        a_ready, a_valid;
  logic [6:0]  a_op;
  logic [2:0]  a_func, a_csr;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [31:0] a_imm;
  logic [1:0]  a_count;

  logic        b_ready, b_valid;
  logic [6:0]  b_op;
  logic [2:0]  b_func, b_csr;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [31:0] b_imm;
  logic [2:0]  b_count;

  ysyx_24110006_idu_fifo #(.DEPTH(2), .IMM_EXT(0)) dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_inst(inst), .i_imm(imm_in),
    .i_valid(valid), .o_ready(a_ready), .i_flush(flush), .o_valid(a_valid),
    .i_ready(ready), .o_op(a_op), .o_func(a_func), .o_reg_rd(a_rd),
    .o_reg_rs1(a_rs1), .o_reg_rs2(a_rs2), .o_imm(a_imm), .o_csr_t(a_csr),
    .o_count(a_count)
  );

  ysyx_24110006_idu_fifo #(.DEPTH(4), .IMM_EXT(1)) dut_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_inst(inst), .i_imm(imm_in),
    .i_valid(valid), .o_ready(b_ready), .i_flush(flush), .o_valid(b_valid),
    .i_ready(ready), .o_op(b_op), .o_func(b_func), .o_reg_rd(b_rd),
    .o_reg_rs1(b_rs1), .o_reg_rs2(b_rs2), .o_imm(b_imm), .o_csr_t(b_csr),
    .o_count(b_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] imm;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   mcount [2] = '{0, 0};
  int   depth  [2] = '{2, 4};
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Immediate as a signed integer built from weighted bit fields.
  function automatic logic [31:0] ref_imm(input logic [31:0] x);
    int v;
    case (x[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
        v = int'(x[31:20]) - (x[31] ? 4096 : 0);
      7'b0110111, 7'b0010111:
        v = int'(x[31:12]) * 4096;
      7'b1101111:
        v = int'(x[19:12]) * 4096 + (x[20] ? 2048 : 0) + int'(x[30:21]) * 2
            - (x[31] ? 1048576 : 0);
      7'b0100011:
        v = int'(x[31:25]) * 32 + int'(x[11:7]) - (x[31] ? 4096 : 0);
      7'b1100011:
        v = (x[7] ? 2048 : 0) + int'(x[30:25]) * 32 + int'(x[11:8]) * 2
            - (x[31] ? 4096 : 0);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [2:0] ref_csr(input logic [31:0] x);
    if (x[6:0] != 7'b1110011) return 3'b111;
    if (x[14:12] == 3'b100) return 3'b111;
    if (x[14:12] == 3'b000) begin
      if (x[21]) return 3'b000;
      return x[20] ? 3'b010 : 3'b011;
    end
    if (x[13:12] == 2'b01) return 3'b001;
    if (x[13:12] == 2'b10) return 3'b100;
    return 3'b101;
  endfunction

  // Reference model: apply the edge's handshake and record accepted entries.
  always @(posedge clk) begin
    if (!rst_n || flush) begin
      mcount = '{0, 0};
      q_a.delete();
      q_b.delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit enq, deq;
        exp_t e;
        enq = valid && (mcount[d] < depth[d]);
        deq = (mcount[d] > 0) && ready;
        if (enq) begin
          e.inst = inst;
          e.imm  = (d == 0) ? ref_imm(inst) : imm_in;
          if (d == 0) q_a.push_back(e);
          else        q_b.push_back(e);
        end
        mcount[d] = mcount[d] + int'(enq) - int'(deq);
      end
    end
  end

  task automatic check_dut(input int d, input logic v, input logic r, input logic [31:0] cnt,
                           input logic [6:0] op, input logic [2:0] fn, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] im, input logic [2:0] cs);
    string p;
    exp_t  e;
    bit    has;
    p = (d == 0) ? "a" : "b";
    if (!rst_n) begin
      chk({p, "_rst_valid"}, 32'(v), 32'd0);
      chk({p, "_rst_ready"}, 32'(r), 32'd1);
      chk({p, "_rst_count"}, cnt, 32'd0);
      chk({p, "_rst_csr"}, 32'(cs), 32'd7);
      return;
    end
    chk({p, "_count"}, cnt, 32'(mcount[d]));
    chk({p, "_valid"}, 32'(v), 32'(mcount[d] > 0));
    chk({p, "_ready"}, 32'(r), 32'(mcount[d] < depth[d]));
    if (v) begin
      has = (d == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
      if (!has) begin
        chk({p, "_unexpected_entry"}, 32'(v), 32'd0);
      end else begin
        e = (d == 0) ? q_a[0] : q_b[0];
        chk({p, "_op"},  32'(op),  32'(e.inst[6:0]));
        chk({p, "_func"}, 32'(fn), 32'(e.inst[14:12]));
        chk({p, "_rd"},  32'(rd),  32'(e.inst[11:7]));
        chk({p, "_rs1"}, 32'(rs1), 32'(e.inst[19:15]));
        chk({p, "_rs2"}, 32'(rs2), 32'(e.inst[24:20]));
        chk({p, "_imm"}, im, e.imm);
        chk({p, "_csr"}, 32'(cs), 32'(ref_csr(e.inst)));
        if (ready && !flush) begin
          if (d == 0) void'(q_a.pop_front());
          else        void'(q_b.pop_front());
        end
      end
    end else begin
      chk({p, "_idle_fields"}, {op, fn, rd, rs1, rs2}, 32'd0);
      chk({p, "_idle_imm"}, im, 32'd0);
      chk({p, "_idle_csr"}, 32'(cs), 32'd7);
    end
  endtask

  // Monitor: compare both instances away from the active edge.
  always @(negedge clk) begin
    check_dut(0, a_valid, a_ready, 32'(a_count), a_op, a_func, a_rd, a_rs1, a_rs2, a_imm, a_csr);
    check_dut(1, b_valid, b_ready, 32'(b_count), b_op, b_func, b_rd, b_rs1, b_rs2, b_imm, b_csr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [6:0]  ops [10] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0110111,
                            7'b0010111, 7'b1101111, 7'b0100011, 7'b1100011, 7'b0110011};
  logic [31:0] csr_insts [4] = '{32'h3020_0073, 32'h0000_0073, 32'h0010_0073, 32'h3052_9073};
  logic [2:0]  csr_exp   [4] = '{3'b000, 3'b011, 3'b010, 3'b001};

  initial begin
    logic [31:0] r;
    rst_n = 1'b0; inst = 32'h0; imm_in = 32'h0;
    valid = 1'b0; ready = 1'b0; flush = 1'b0;
    #3;
    chk("reset_valid", 32'(a_valid), 32'd0);
    chk("reset_ready", 32'(a_ready), 32'd1);
    chk("reset_count", 32'(a_count), 32'd0);
    chk("reset_csr", 32'(a_csr), 32'd7);
    step(); step();
    rst_n = 1'b1;

    // addi x1,x0,5
    valid = 1'b1; inst = 32'h0050_0093; imm_in = 32'h11;
    step();
    valid = 1'b0;
    chk("addi_valid", 32'(a_valid), 32'd1);
    chk("addi_op", 32'(a_op), 32'h13);
    chk("addi_rd", 32'(a_rd), 32'd1);
    chk("addi_imm", a_imm, 32'd5);
    chk("addi_csr", 32'(a_csr), 32'd7);
    ready = 1'b1; step(); ready = 1'b0;

    // back-to-back fill while downstream stalls
    valid = 1'b1;
    inst = 32'h0010_0113; step();
    inst = 32'h0020_0193; step();
    chk("full_count", 32'(a_count), 32'd2);
    chk("full_ready", 32'(a_ready), 32'd0);
    inst = 32'h0030_0213; step();
    chk("held_count", 32'(a_count), 32'd2);
    ready = 1'b1; step();
    chk("after_deq_count", 32'(a_count), 32'd1);
    chk("after_deq_ready", 32'(a_ready), 32'd1);
    valid = 1'b0;
    repeat (5) step();
    ready = 1'b0;

    // SYSTEM classes
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; inst = csr_insts[i]; step();
      valid = 1'b0;
      chk($sformatf("csr_seq%0d", i), 32'(a_csr), 32'(csr_exp[i]));
      ready = 1'b1; step(); ready = 1'b0;
    end

    // branch and jump immediates
    valid = 1'b1; inst = 32'hFE00_0EE3; step(); valid = 1'b0;
    chk("beq_imm", a_imm, 32'hFFFF_FFFC);
    ready = 1'b1; step(); ready = 1'b0;
    valid = 1'b1; inst = 32'h8000_00EF; step(); valid = 1'b0;
    chk("jal_imm", a_imm, 32'hFFF0_0000);
    ready = 1'b1; step(); ready = 1'b0;

    // flush with simultaneous enqueue/dequeue
    valid = 1'b1; inst = 32'h0040_0293; step();
    inst = 32'h0050_0313; ready = 1'b1; flush = 1'b1; step();
    flush = 1'b0; valid = 1'b0; ready = 1'b0;
    chk("flush_count", 32'(a_count), 32'd0);
    chk("flush_valid", 32'(a_valid), 32'd0);
    chk("flush_b_count", 32'(b_count), 32'd0);
    step();
    chk("flush_no_enq", 32'(a_valid), 32'd0);

    // external immediates with wrapped pointers on the 4-deep instance
    valid = 1'b1;
    for (int k = 0; k < 2; k++) begin inst = 32'h0000_0013; imm_in = 32'(100 + k); step(); end
    valid = 1'b0; ready = 1'b1; step(); step(); ready = 1'b0;
    valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin inst = 32'h0000_0033; imm_in = 32'(k); step(); end
    valid = 1'b0;
    chk("ext_full_count", 32'(b_count), 32'd4);
    ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ext_imm%0d", k), b_imm, 32'(k));
      step();
    end
    ready = 1'b0;

    // reset pulse mid-stream
    valid = 1'b1; imm_in = 32'hAA; step(); step();
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_b_valid", 32'(b_valid), 32'd0);
    chk("midrst_a_valid", 32'(a_valid), 32'd0);
    chk("midrst_b_count", 32'(b_count), 32'd0);
    chk("midrst_b_ready", 32'(b_ready), 32'd1);
    step();
    rst_n = 1'b1;

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      r      = $urandom();
      inst   = {r[31:7], ops[$urandom_range(0, 9)]};
      imm_in = $urandom();
      valid  = ($urandom_range(0, 3) != 0);
      ready  = ($urandom_range(0, 2) != 0);
      flush  = ($urandom_range(0, 19) == 0);
      step();
    end
    flush = 1'b0; valid = 1'b0; ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
